// File: rtl/dmem_responder_if.sv
// DMEM request/acknowledge bundle between the execution unit (master) and dmem_responder (slave).
// Latency: none, this is wiring only.
// Backpressure: the master holds req until it sees ack. The slave ignores req while an access is in flight.
// Signals: req/addr/we/wdata go master->slave. rdata/ack (and err when DMEM_ERR_CHECK_EN is defined) go slave->master.
interface dmem_responder_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          req;
  logic [AW-1:0] addr;
  logic          we;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;
`ifdef DMEM_ERR_CHECK_EN
  logic          err;

  modport master (output req, addr, we, wdata, input rdata, ack, err);
  modport slave  (input req, addr, we, wdata, output rdata, ack, err);
`else
  modport master (output req, addr, we, wdata, input rdata, ack);
  modport slave  (input req, addr, we, wdata, output rdata, ack);
`endif
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory that responds to the execution unit's DMEM request/ack port.
// Latency: a request accepted in IDLE is acked LATENCY cycles later. With req held high, one access completes every LATENCY+1 cycles.
// Backpressure: only one access is in flight at a time. req is ignored in BUSY and ACK and is sampled again in IDLE.
// Ports:
//   clk_i  - rising-edge clock
//   rst_ni - synchronous active-low reset
//   dmem   - slave modport carrying req/addr/we/wdata in and rdata/ack out
// Optional feature: define DMEM_ERR_CHECK_EN to add dmem.err, which flags out-of-range accesses in their ack cycle.
module dmem_responder #(
  parameter int unsigned MEM_ADDR_WIDTH = 32,  // matches simple_processor_pkg::ADDR_WIDTH
  parameter int unsigned MEM_DATA_WIDTH = 32,  // matches simple_processor_pkg::DATA_WIDTH
  parameter int unsigned DEPTH_WORDS    = 256,
  parameter int unsigned LATENCY        = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  dmem_responder_if.slave dmem
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be in 1..15");
  end
  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("dmem_responder: DEPTH_WORDS must be a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      we_q, we_d;
  logic [MEM_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MEM_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      ack_q, ack_d;
`ifdef DMEM_ERR_CHECK_EN
  logic                      err_q, err_d;
`endif

  logic [MEM_DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Access seen by the commit edge. It normally comes from the latched copy.
  // With LATENCY == 1 the commit edge is also the accept edge, so the live inputs are used.
  logic                      commit;
  logic [MEM_ADDR_WIDTH-1:0] acc_addr;
  logic                      acc_we;
  logic [MEM_DATA_WIDTH-1:0] acc_wdata;
  logic                      in_range;
  logic [IDX_W-1:0]          idx;

  always_comb begin
    acc_addr  = addr_q;
    acc_we    = we_q;
    acc_wdata = wdata_q;
    if (state_q == IDLE) begin
      acc_addr  = dmem.addr;
      acc_we    = dmem.we;
      acc_wdata = dmem.wdata;
    end
  end

  // Any address bit at or above the index width puts the access out of range.
  // Such an access is dropped instead of aliasing onto a low word.
  assign in_range = (acc_addr >> IDX_W) == '0;
  assign idx      = acc_addr[IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    commit  = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (dmem.req) begin
          addr_d  = dmem.addr;
          we_d    = dmem.we;
          wdata_d = dmem.wdata;
          cnt_d   = LAT_M1;
          if (LATENCY == 1) begin
            state_d = ACK;
            commit  = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        // When cnt_q is 1, this edge is the LATENCY-th one after acceptance.
        if (cnt_q == 4'd1) begin
          state_d = ACK;
          commit  = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Read data and ack are registered on the edge that enters ACK, so they become visible together.
    if (commit) begin
      ack_d = 1'b1;
      if (!acc_we) begin
        rdata_d = in_range ? mem[idx] : '0;
      end
`ifdef DMEM_ERR_CHECK_EN
      err_d = !in_range;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
`ifdef DMEM_ERR_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
`ifdef DMEM_ERR_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Storage has no reset. A reset asserted on the commit edge blocks the write.
  always_ff @(posedge clk_i) begin
    if (rst_ni && commit && acc_we && in_range) begin
      mem[idx] <= acc_wdata;
    end
  end

  assign dmem.rdata = rdata_q;
  assign dmem.ack   = ack_q;

`ifdef DMEM_ERR_CHECK_EN
  assign dmem.err = err_q;
`ifdef SIMULATION
  always_ff @(posedge clk_i) begin
    if (rst_ni && commit && !in_range) begin
      $display("dmem_responder: out-of-range access at addr 0x%h", acc_addr);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder at LATENCY=2 and DEPTH_WORDS=256.
// Inputs are driven 1 ns after the rising edge, and outputs are sampled at the same point.
// Each check compares the DUT against values computed by hand.
module tb_dmem_responder;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] hold = 32'h0;  // rdata value expected to be held between load acks

  always #5 clk = ~clk;

  dmem_responder_if #(.AW(32), .DW(32)) dif ();

  dmem_responder #(
    .MEM_ADDR_WIDTH(32),
    .MEM_DATA_WIDTH(32),
    .DEPTH_WORDS   (256),
    .LATENCY       (LAT)
  ) u_dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .dmem  (dif)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The task starts in an IDLE cycle and presents the request there.
  // It returns at the start of the IDLE cycle that follows the ack.
  // exp_rd is the rdata value expected in the ack cycle: the loaded value for a load, the held value for a store.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input string tag);
    dif.req   = 1'b1;
    dif.we    = we;
    dif.addr  = addr;
    dif.wdata = wd;
    for (int i = 1; i < LAT; i++) begin
      tick();
      dif.req = 1'b0;
      chk({tag, "_wait_ack"}, 32'(dif.ack), 32'h0);
    end
    tick();
    dif.req = 1'b0;
    chk({tag, "_ack"}, 32'(dif.ack), 32'h1);
    chk({tag, "_rdata"}, dif.rdata, exp_rd);
`ifdef DMEM_ERR_CHECK_EN
    chk({tag, "_err"}, 32'(dif.err), (addr >= 32'd256) ? 32'h1 : 32'h0);
`endif
    tick();
    chk({tag, "_ack_drop"}, 32'(dif.ack), 32'h0);
`ifdef DMEM_ERR_CHECK_EN
    chk({tag, "_err_drop"}, 32'(dif.err), 32'h0);
`endif
  endtask

  initial begin
    dif.req   = 1'b0;
    dif.we    = 1'b0;
    dif.addr  = '0;
    dif.wdata = '0;

    // Reset, then 5 idle cycles
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    chk("rst_ack", 32'(dif.ack), 32'h0);
    chk("rst_rdata", dif.rdata, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_ack", 32'(dif.ack), 32'h0);
      chk("idle_rdata", dif.rdata, 32'h0);
    end

    // Store then load at 0x10; rdata must still hold at t+8 and across a store ack
    access(1'b1, 32'h10, 32'hDEADBEEF, hold, "st10");
    hold = 32'hDEADBEEF;
    access(1'b0, 32'h10, 32'h0, hold, "ld10");
    tick();
    tick();
    chk("ld10_hold_t8", dif.rdata, 32'hDEADBEEF);
    access(1'b1, 32'h11, 32'h55, hold, "st11_rdata_kept");

    // req held high: stores 1..4 to addr 0..3, then loads; an ack every 3 cycles
    dif.req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dif.we    = (i < 4);
      dif.addr  = 32'(i % 4);
      dif.wdata = 32'(i + 1);
      if (i >= 4) hold = 32'(i - 3);
      tick();
      chk("thr_busy", 32'(dif.ack), 32'h0);
      tick();
      chk("thr_ack", 32'(dif.ack), 32'h1);
      chk("thr_rdata", dif.rdata, hold);
      tick();
      chk("thr_idle", 32'(dif.ack), 32'h0);
    end
    dif.req = 1'b0;

    // Inputs change during BUSY: only the latched addr 7 may be written
    access(1'b1, 32'd8, 32'h88, hold, "st8");
    dif.req   = 1'b1;
    dif.we    = 1'b1;
    dif.addr  = 32'd7;
    dif.wdata = 32'h5;
    tick();
    dif.req   = 1'b0;
    dif.addr  = 32'd8;
    dif.wdata = 32'h99;
    chk("chg_busy", 32'(dif.ack), 32'h0);
    tick();
    chk("chg_ack", 32'(dif.ack), 32'h1);
    tick();
    chk("chg_ack_drop", 32'(dif.ack), 32'h0);
    hold = 32'h5;
    access(1'b0, 32'd7, 32'h0, hold, "ld7");
    hold = 32'h88;
    access(1'b0, 32'd8, 32'h0, hold, "ld8");

    // Reset during BUSY aborts the store to addr 20
    access(1'b1, 32'd20, 32'h1, hold, "st20");
    dif.req   = 1'b1;
    dif.we    = 1'b1;
    dif.addr  = 32'd20;
    dif.wdata = 32'hAAAA5555;
    tick();
    dif.req = 1'b0;
    rst_ni  = 1'b0;
    tick();
    rst_ni = 1'b1;
    hold   = 32'h0;
    chk("abort_ack", 32'(dif.ack), 32'h0);
    chk("abort_rdata_rst", dif.rdata, 32'h0);
    tick();
    chk("abort_ack2", 32'(dif.ack), 32'h0);
    tick();
    chk("abort_ack3", 32'(dif.ack), 32'h0);
    hold = 32'h1;
    access(1'b0, 32'd20, 32'h0, hold, "ld20");

    // Out-of-range accesses and the top in-range word
    access(1'b1, 32'h0, 32'h1234, hold, "st0");
    hold = 32'h0;
    access(1'b0, 32'h100, 32'h0, hold, "ld100_oor");
    access(1'b1, 32'h100, 32'hFFFF, hold, "st100_oor");
    hold = 32'h1234;
    access(1'b0, 32'h0, 32'h0, hold, "ld0_no_alias");
    access(1'b1, 32'hFF, 32'hCAFE, hold, "stFF");
    hold = 32'hCAFE;
    access(1'b0, 32'hFF, 32'h0, hold, "ldFF");
    hold = 32'h0;
    access(1'b0, 32'h80000000, 32'h0, hold, "ld_hi_oor");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory target for the processor's DMEM port: the responder end of the request/acknowledge interface driven by the execution unit. It accepts one word access per request, stalls a programmable number of cycles, then commits the write or returns the read data with a single-cycle ack. It contains a word-addressed storage array and is instantiated beside the execution unit in the core top.

Parameters:
MEM_ADDR_WIDTH, simple_processor_pkg::ADDR_WIDTH (32), width of the DMEM address bus
MEM_DATA_WIDTH, simple_processor_pkg::DATA_WIDTH (32), width of the DMEM data buses and of each storage word
DEPTH_WORDS, 256, number of storage words; power of two, at least 2
LATENCY, 2, cycles from request acceptance to ack; legal range 1..15

Ports:
clk_i  input  1  single clock, all logic on the rising edge
rst_ni  input  1  reset, synchronous, active-low
dmem_req_i  input  1  access request, level; the initiator may hold it permanently high
dmem_addr_i  input  MEM_ADDR_WIDTH  word address (not byte address)
dmem_we_i  input  1  1 = store, 0 = load
dmem_wdata_i  input  MEM_DATA_WIDTH  store data
dmem_rdata_o  output  MEM_DATA_WIDTH  load data, valid in the ack cycle and held until the next load ack
dmem_ack_o  output  1  single-cycle completion pulse

Behaviour:
- Reset (rst_ni low at a rising edge): state returns to IDLE; dmem_ack_o = 0; dmem_rdata_o = 0; the latency counter clears.
- Storage contents are not reset.
- Reset mid-transaction aborts the access: no write is committed and no ack is issued.
- FSM has three states: IDLE, BUSY, ACK.
  - IDLE: if dmem_req_i = 1 at the edge, latch addr, we and wdata, and load the counter with LATENCY-1.
    - LATENCY = 1: go to ACK.
    - Otherwise: go to BUSY.
  - BUSY: decrement the counter each cycle. When it reaches 0, go to ACK.
    - Input changes during BUSY are ignored; only the latched values are used.
  - ACK: dmem_ack_o = 1 for exactly this cycle, then return to IDLE.
    - A request present during the ACK cycle is not accepted. It is sampled next in IDLE.
- Latency: request sampled in cycle t, ack high in cycle t+LATENCY.
- Throughput with req held high: one access per LATENCY+1 cycles.
- The storage write and the dmem_rdata_o register update happen on the edge that enters ACK. This makes read data valid together with ack.
- A load issued after a store to the same address returns the stored value (no stale read).
- Store acks leave dmem_rdata_o unchanged.
- Index = latched addr[$clog2(DEPTH_WORDS)-1:0].
- Out of range (latched addr >= DEPTH_WORDS):
  - The store is dropped with no aliasing.
  - The load returns 0.
  - Ack is still issued with normal timing.
- dmem_ack_o and dmem_rdata_o are driven from registers only, with no combinational path from inputs.

Optional Feature:
Macro DMEM_ERR_CHECK_EN.
- Defined:
  - Adds output port dmem_err_o (1 bit, reset 0).
  - dmem_err_o is asserted in the same cycle as dmem_ack_o for an out-of-range access; otherwise it is 0.
  - Under SIMULATION, each error also prints the offending address via $display.
- Not defined:
  - The port is absent.
  - Out-of-range accesses are still dropped or read as 0 silently.

Test Plan:
- Reset, then idle with req = 0 for 5 cycles -> ack stays 0, rdata = 0x00000000.
- LATENCY = 2: store addr 0x10, wdata 0xDEADBEEF, req in cycle t -> ack only in cycle t+2, one cycle wide. Then load addr 0x10 accepted at t+3 -> ack at t+5 with rdata = 0xDEADBEEF, and rdata still 0xDEADBEEF at t+8.
- req held high with alternating stores to addr 0..3 (values 1..4) followed by loads -> an ack every 3 cycles; loads return 1, 2, 3, 4 in order.
- Change addr/we/wdata during BUSY (store 0x5 to addr 7, switched to addr 8 mid-wait) -> only addr 7 is written; a later load of addr 8 returns its prior value.
- rst_ni low for one edge during BUSY of a store to addr 20 with 0xAAAA5555 (addr 20 previously 0x1) -> no ack; a later load of addr 20 returns 0x1.
- Load addr 0x100 with DEPTH_WORDS = 256 -> ack after LATENCY, rdata = 0. With DMEM_ERR_CHECK_EN: dmem_err_o = 1 in the ack cycle only. A store to 0x100 does not alter word 0x00.
